nanov_serial_alu: RTL and testbench
===================================

NANOV_SERIAL_ALU -- requirements
Module: nanoV_serial_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have parameter DIGIT_W, default 1, meaning bits processed per cycle; legal values 1, 2, 4, 8; XLEN SHALL be a multiple of DIGIT_W.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port op  input  4  operation: op[2:0] funct3-style select, op[3] subtract/arithmetic modifier.
REQ-007 SHALL have ports a, b  input  XLEN  operands.
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-009 SHALL have port done  output  1  one-cycle pulse, d valid.
REQ-010 SHALL have port d  output  XLEN  result, held until the next accepted start completes.

Function
REQ-011 SHALL accept start only on an edge where busy=0; op, a and b captured on that edge (E0); later input changes have no effect.
REQ-012 SHALL use states IDLE, RUN, SHIFT (SHIFT only with REQ-024); IDLE->RUN on accepted non-shift op; RUN->IDLE after N=XLEN/DIGIT_W digit cycles.
REQ-013 SHALL process digit k (bits k*DIGIT_W+DIGIT_W-1 : k*DIGIT_W), LSB digit first, one digit per cycle, using a registered carry between digits.
REQ-014 SHALL assert done for exactly one cycle after edge E0+N for RUN ops; busy=1 from E0 until that same edge, and busy=0 while done=1.
REQ-015 SHALL accept a start in the cycle done=1 (back-to-back, no idle gap).
REQ-016 SHALL implement op[2:0]=000: op[3]=0 ADD, op[3]=1 SUB (a + ~b + 1); result modulo 2^XLEN.
REQ-017 SHALL implement 010 SLT: d = {0..., signed a<b}, computed as a-b with overflow correction (sign of a if signs differ, else sign of difference).
REQ-018 SHALL implement 011 SLTU: d = {0..., ~carry_out of a + ~b + 1}.
REQ-019 SHALL implement 100 XOR, 110 OR, 111 AND bitwise; op[3] ignored.
REQ-020 SHALL force initial carry to 1 when op[1]|op[3] for arithmetic/compare ops, else 0.
REQ-021 SHALL update d only on the edge that raises done; d unchanged while busy.

Reset
REQ-022 SHALL on rstn=0 at any edge, including mid-operation: state IDLE, busy=0, done=0, d=0, digit counter and carry 0; in-flight operation discarded with no done.
REQ-023 SHALL ignore start on an edge where rstn=0.

Configuration
REQ-024 SHALL, with macro NANOV_SERIAL_ALU_SHIFT_EN defined, implement 001 SLL, 101 op[3]=0 SRL, 101 op[3]=1 SRA: shamt=b[log2(XLEN)-1:0], a loaded to a shift register, shifted one bit per cycle in SHIFT state, done after edge E0+max(shamt,1).
REQ-025 SHALL, without NANOV_SERIAL_ALU_SHIFT_EN, treat op 001/101 as RUN ops producing d=0 with latency N; no SHIFT state logic present.

Verification
REQ-026 SHALL cover: DIGIT_W=1, ADD a=5 b=7 -> d=0x0000000C, done exactly 32 cycles after E0, busy low with done.
REQ-027 SHALL cover: SUB a=3 b=5 -> d=0xFFFFFFFE; SLT a=0xFFFFFFFF b=1 -> d=1; SLTU same operands -> d=0; SLT a=0x80000000 b=0x7FFFFFFF -> d=1.
REQ-028 SHALL cover: DIGIT_W=4, AND a=0xF0F0F0F0 b=0xFF00FF00 -> d=0xF000F000, done 8 cycles after E0; back-to-back OR 0x1|0x2 started in done cycle -> d=0x3 after 8 further cycles.
REQ-029 SHALL cover: start held high while busy -> single operation, single done pulse; inputs changed after E0 -> result unaffected.
REQ-030 SHALL cover: rstn low at cycle 10 of a 32-cycle ADD -> busy=0, done=0, d=0 next cycle, no done pulse afterwards.
REQ-031 SHALL cover with NANOV_SERIAL_ALU_SHIFT_EN: SLL a=1 shamt=31 -> 0x80000000 done after 31 cycles; SRA a=0x80000000 shamt=4 -> 0xF8000000; SRL same -> 0x08000000; shamt=0 -> d=a after 1 cycle.

Source files
------------

// File: rtl/nanov_serial_alu.sv
// Digit-serial RV32-style ALU: XLEN bits processed DIGIT_W bits per cycle.
// Define NANOV_SERIAL_ALU_SHIFT_EN to add the bit-serial SLL/SRL/SRA path.
module nanov_serial_alu #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] d
);

    localparam int N  = XLEN / DIGIT_W;
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

`ifdef NANOV_SERIAL_ALU_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SHIFT = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
`endif

    state_t state, state_nx;

    logic [3:0]         op_q;
    logic [XLEN-1:0]    sa;
    logic [XLEN-1:0]    sb;
    logic [XLEN-1:0]    acc;
    logic               carry;
    logic [CW-1:0]      cnt;

    logic               last_dig;
    logic               fin;
    logic               is_shift;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] res_dig;
    logic [XLEN-1:0]    acc_nx;
    logic [XLEN-1:0]    run_d;
    logic               slt_bit;
    logic               sltu_bit;

    assign last_dig = (cnt == CW'(N - 1));

`ifdef NANOV_SERIAL_ALU_SHIFT_EN
    logic            sh_last;
    logic [XLEN-1:0] sh_nx;
    logic [XLEN-1:0] sh_d;

    assign is_shift = (op[1:0] == 2'b01);
    // cnt holds the remaining shift amount while in SHIFT
    assign sh_last  = (cnt <= CW'(1));

    always_comb begin
        sh_nx = sa << 1;
        if (op_q[2]) begin
            sh_nx = op_q[3] ? {sa[XLEN-1], sa[XLEN-1:1]} : (sa >> 1);
        end
        sh_d = (cnt == '0) ? sa : sh_nx;
    end
`else
    assign is_shift = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef NANOV_SERIAL_ALU_SHIFT_EN
                    state_nx = is_shift ? SHIFT : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                if (last_dig) state_nx = IDLE;
            end
`ifdef NANOV_SERIAL_ALU_SHIFT_EN
            SHIFT: begin
                if (sh_last) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        busy = (state != IDLE);
        fin  = (state == RUN) && last_dig;
`ifdef NANOV_SERIAL_ALU_SHIFT_EN
        if (state == SHIFT) fin = sh_last;
`endif
    end

    // digit datapath: compares and SUB run on a + ~b + 1
    always_comb begin
        a_dig    = sa[DIGIT_W-1:0];
        b_dig    = sb[DIGIT_W-1:0];
        b_eff    = (op_q[3] | op_q[1]) ? ~b_dig : b_dig;
        sum      = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, carry};
        res_dig  = '0;
        case (op_q[2:0])
            3'b000:  res_dig = sum[DIGIT_W-1:0];
            3'b100:  res_dig = a_dig ^ b_dig;
            3'b110:  res_dig = a_dig | b_dig;
            3'b111:  res_dig = a_dig & b_dig;
            default: res_dig = '0;
        endcase
        acc_nx   = {res_dig, acc[XLEN-1:DIGIT_W]};
        slt_bit  = (a_dig[DIGIT_W-1] != b_dig[DIGIT_W-1]) ?
                   a_dig[DIGIT_W-1] : sum[DIGIT_W-1];
        sltu_bit = ~sum[DIGIT_W];
        case (op_q[2:0])
            3'b010:  run_d = {{(XLEN-1){1'b0}}, slt_bit};
            3'b011:  run_d = {{(XLEN-1){1'b0}}, sltu_bit};
            default: run_d = acc_nx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q  <= '0;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            d     <= '0;
        end else begin
            done <= fin;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sa    <= a;
                        sb    <= b;
                        acc   <= '0;
                        carry <= ~op[2] & (op[1] | op[3]);
                        cnt   <= is_shift ? b[CW-1:0] : '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> DIGIT_W;
                    sb    <= sb >> DIGIT_W;
                    acc   <= acc_nx;
                    carry <= sum[DIGIT_W];
                    cnt   <= cnt + CW'(1);
                    if (last_dig) begin
                        d     <= run_d;
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
`ifdef NANOV_SERIAL_ALU_SHIFT_EN
                SHIFT: begin
                    if (cnt != '0) begin
                        sa  <= sh_nx;
                        cnt <= cnt - CW'(1);
                    end
                    if (sh_last) begin
                        d   <= sh_d;
                        cnt <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_serial_alu.sv
// Scoreboard bench for nanov_serial_alu: one DIGIT_W=1 and one DIGIT_W=4 instance.
// Shift checks are built only when NANOV_SERIAL_ALU_SHIFT_EN is defined.
module tb_nanov_serial_alu;

    typedef struct {
        logic [31:0] d;
        int          lat;
        int          e0;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start1, start4;
    logic [3:0]  op1, op4;
    logic [31:0] a1, b1, a4, b4;
    logic        busy1, done1, busy4, done4;
    logic [31:0] d1, d4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    logic [31:0] last_d1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nanov_serial_alu #(.XLEN(32), .DIGIT_W(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .op(op1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .d(d1)
    );

    nanov_serial_alu #(.XLEN(32), .DIGIT_W(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .op(op4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .d(d4)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_d(input logic [3:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        case (o[2:0])
            3'b000: r = o[3] ? x - y : x + y;
            3'b010: r = {31'b0, $signed(x) < $signed(y)};
            3'b011: r = {31'b0, x < y};
            3'b100: r = x ^ y;
            3'b110: r = x | y;
            3'b111: r = x & y;
`ifdef NANOV_SERIAL_ALU_SHIFT_EN
            3'b001: r = x << y[4:0];
            3'b101: r = o[3] ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
`endif
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [31:0] y,
                                   input int n);
`ifdef NANOV_SERIAL_ALU_SHIFT_EN
        if (o[1:0] == 2'b01) return (y[4:0] == 5'd0) ? 1 : int'(y[4:0]);
`endif
        return n;
    endfunction

    // drives start in the current cycle; the next rising edge is E0
    task automatic issue(input int u, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.d   = ref_d(o, x, y);
        e.lat = ref_lat(o, y, (u == 1) ? 32 : 8);
        e.e0  = cyc + 1;
        e.tag = $sformatf("u%0d_op%0h_%0h_%0h", u, o, x, y);
        if (u == 1) begin
            start1 = 1'b1; op1 = o; a1 = x; b1 = y;
            q1.push_back(e);
        end else begin
            start4 = 1'b1; op4 = o; a4 = x; b4 = y;
            q4.push_back(e);
        end
    endtask

    task automatic drain(input int u);
        int sz;
        for (int n = 0; n < 100; n++) begin
            sz = (u == 1) ? q1.size() : q4.size();
            if (sz == 0) break;
            @(negedge clk);
        end
        sz = (u == 1) ? q1.size() : q4.size();
        chk($sformatf("drain_u%0d", u), 64'(sz), 64'd0);
    endtask

    // one operation, operands scrambled right after E0
    task automatic go(input int u, input logic [3:0] o,
                      input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        issue(u, o, x, y);
        @(negedge clk);
        if (u == 1) begin
            start1 = 1'b0; a1 = $urandom; b1 = $urandom; op1 = 4'(~o);
        end else begin
            start4 = 1'b0; a4 = $urandom; b4 = $urandom; op4 = 4'(~o);
        end
        drain(u);
    endtask

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_done", {63'b0, done1}, 64'd0);
            end else begin
                e1 = q1.pop_front();
                chk({e1.tag, "_d"}, {32'b0, d1}, {32'b0, e1.d});
                chk({e1.tag, "_lat"}, 64'(cyc - e1.e0), 64'(e1.lat));
                chk({e1.tag, "_busy"}, {63'b0, busy1}, 64'd0);
                last_d1 = e1.d;
            end
        end
        if (done4) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_done", {63'b0, done4}, 64'd0);
            end else begin
                e4 = q4.pop_front();
                chk({e4.tag, "_d"}, {32'b0, d4}, {32'b0, e4.d});
                chk({e4.tag, "_lat"}, 64'(cyc - e4.e0), 64'(e4.lat));
                chk({e4.tag, "_busy"}, {63'b0, busy4}, 64'd0);
            end
        end
    end

    initial begin
        logic [3:0] ops [7];
        ops = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};
        rstn = 1'b0;
        start1 = 1'b0; start4 = 1'b0;
        op1 = '0; op4 = '0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy1", {63'b0, busy1}, 64'd0);
        chk("rst_done1", {63'b0, done1}, 64'd0);
        chk("rst_d1", {32'b0, d1}, 64'd0);
        chk("rst_busy4", {63'b0, busy4}, 64'd0);
        chk("rst_d4", {32'b0, d4}, 64'd0);
        rstn = 1'b1;

        go(1, 4'h0, 32'd5, 32'd7);
        go(1, 4'h8, 32'd3, 32'd5);
        go(1, 4'h2, 32'hFFFF_FFFF, 32'd1);
        go(1, 4'h3, 32'hFFFF_FFFF, 32'd1);
        go(1, 4'h2, 32'h8000_0000, 32'h7FFF_FFFF);
        go(1, 4'hA, 32'h7FFF_FFFF, 32'h8000_0000);
        go(1, 4'h3, 32'd4, 32'd4);
        go(1, 4'h4, 32'hA5A5_0F0F, 32'h5A5A_FFFF);
        go(1, 4'h0, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 4; i++) begin
            go(1, ops[$urandom_range(0, 6)], $urandom, $urandom);
        end

        go(4, 4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00);
        // back-to-back: second start lands in the done cycle
        @(negedge clk);
        issue(4, 4'h0, 32'h0FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        start4 = 1'b0;
        for (int n = 0; n < 40 && !done4; n++) @(negedge clk);
        chk("b2b_done4_seen", {63'b0, done4}, 64'd1);
        issue(4, 4'h6, 32'h1, 32'h2);
        @(negedge clk);
        start4 = 1'b0; a4 = $urandom; b4 = $urandom;
        drain(4);
        repeat (5) @(negedge clk);
        chk("d4_hold", {32'b0, d4}, 64'h3);
        for (int i = 0; i < 4; i++) begin
            go(4, ops[$urandom_range(0, 6)], $urandom, $urandom);
        end

        // start held high across most of a run: only one operation
        @(negedge clk);
        issue(1, 4'h0, 32'h1234_0000, 32'h0000_5678);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            a1 = $urandom; b1 = $urandom;
        end
        chk("hold_busy1", {63'b0, busy1}, 64'd1);
        chk("hold_d1_unchanged", {32'b0, d1}, {32'b0, last_d1});
        start1 = 1'b0;
        drain(1);
        repeat (40) @(negedge clk);

`ifdef NANOV_SERIAL_ALU_SHIFT_EN
        go(1, 4'h1, 32'h1, 32'd31);
        go(1, 4'hD, 32'h8000_0000, 32'd4);
        go(1, 4'h5, 32'h8000_0000, 32'd4);
        go(1, 4'h1, 32'h1234_5678, 32'd0);
        go(1, 4'h5, 32'hF000_000F, 32'h0000_0021);
`else
        go(1, 4'h1, 32'd5, 32'd1);
        go(1, 4'hD, 32'h8000_0000, 32'd4);
`endif

        // reset ten cycles into an ADD: no done, all outputs cleared
        @(negedge clk);
        start1 = 1'b1; op1 = 4'h0; a1 = 32'd9; b1 = 32'd9;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy1", {63'b0, busy1}, 64'd0);
        chk("rst_mid_done1", {63'b0, done1}, 64'd0);
        chk("rst_mid_d1", {32'b0, d1}, 64'd0);
        start1 = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_start_ignored", {63'b0, busy1}, 64'd0);
        last_d1 = '0;
        repeat (40) @(negedge clk);
        go(1, 4'h0, 32'd5, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
